// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_t : top-level session FSM states
//   BYTES_PER_WORD : stream bytes per 32-bit instruction word
//   HDR_W          : width of the little-endian word-count header
// -----------------------------------------------------------------------------
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = 32;

endpackage : inst_loader_pkg

// File: rtl/inst_loader_byte_to_word_asm.sv
// -----------------------------------------------------------------------------
// byte_to_word_asm
// Assembles a little-endian 32-bit word from four accepted stream bytes.
// The first byte lands in bits [7:0]. One cycle after the fourth byte is
// accepted, word_vld_o pulses for a single cycle with the word on word_o.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clr_i         : restart assembly at byte 0 (new session)
//   byte_vld_i    : a byte is accepted this cycle
//   byte_i        : the accepted byte
//   byte_cnt_o    : position (0..3) of the next byte within the word
//   word_vld_o    : one-cycle strobe, assembled word is valid
//   word_o        : assembled word, held between strobes
// -----------------------------------------------------------------------------
module byte_to_word_asm
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_cnt_o,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;
  logic        word_vld_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      word_vld_q <= 1'b0;
      word_q     <= '0;
    end else if (clr_i) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      word_vld_q <= 1'b0;
    end else begin
      word_vld_q <= 1'b0;
      if (byte_vld_i) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
          // Last byte goes straight into the top lane, earlier bytes below.
          word_q     <= {byte_i, shift_q};
          word_vld_q <= 1'b1;
        end else begin
          // Right shift so the earliest byte ends up in the lowest lane.
          shift_q <= {byte_i, shift_q[23:8]};
        end
      end
    end
  end

  assign byte_cnt_o = cnt_q;
  assign word_vld_o = word_vld_q;
  assign word_o     = word_q;

endmodule : byte_to_word_asm

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Receives a byte stream (4-byte LE word count N, then 4*N data bytes),
// writes each assembled word into instruction memory, and holds the core in
// reset until a full program image has been written.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : one-cycle pulse, begins a session (IDLE/DONE/ERROR)
//   in_valid, in_data     : byte source
//   in_ready              : loader accepts a byte this cycle
//   mem_we, mem_addr,
//   mem_wdata             : instruction memory write port (word-indexed)
//   words_loaded          : words written in the current session
//   busy                  : session in progress
//   done                  : program loaded completely
//   error                 : header word count exceeded Depth
//   core_hold             : keeps the core in reset (NOT done)
// -----------------------------------------------------------------------------
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int AddrSize  = 32,
  parameter int Inst_Size = 32,
  parameter int Depth     = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [AddrSize-1:0]  mem_addr,
  output logic [Inst_Size-1:0] mem_wdata,
  output logic [AddrSize-1:0]  words_loaded,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 core_hold
);

  localparam logic [HDR_W-1:0] DEPTH_W = HDR_W'(Depth);

  loader_state_t       state_q, state_d;
  logic [HDR_W-1:0]    len_q, len_d;
  logic [1:0]          hdr_cnt_q, hdr_cnt_d;
  logic [AddrSize-1:0] words_loaded_q, words_loaded_d;
  logic [AddrSize-1:0] mem_addr_q, mem_addr_d;
  logic                last_q, last_d;

  logic                accept;
  logic                start_sess;
  logic [HDR_W-1:0]    len_full;
  logic                asm_byte_vld;
  logic [1:0]          asm_cnt;
  logic                asm_word_vld;
  logic [31:0]         asm_word;
  logic                word_done;
  logic [AddrSize-1:0] len_words;
  logic [AddrSize-1:0] last_idx;

  assign in_ready     = (state_q == LEN) || ((state_q == DATA) && !last_q);
  assign accept       = in_valid && in_ready;
  assign start_sess   = start && ((state_q == IDLE) || (state_q == DONE) ||
                                  (state_q == ERROR));
  assign len_full     = {in_data, len_q[HDR_W-1:8]};
  assign asm_byte_vld = accept && (state_q == DATA);
  assign word_done    = asm_byte_vld && (asm_cnt == 2'(BYTES_PER_WORD - 1));
  assign len_words    = AddrSize'(len_q);
  assign last_idx     = AddrSize'(len_q - HDR_W'(1));

  byte_to_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start_sess),
    .byte_vld_i (asm_byte_vld),
    .byte_i     (in_data),
    .byte_cnt_o (asm_cnt),
    .word_vld_o (asm_word_vld),
    .word_o     (asm_word)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    hdr_cnt_d      = hdr_cnt_q;
    words_loaded_d = words_loaded_q;
    mem_addr_d     = mem_addr_q;
    last_d         = last_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d        = LEN;
          len_d          = '0;
          hdr_cnt_d      = '0;
          words_loaded_d = '0;
          last_d         = 1'b0;
        end
      end
      LEN: begin
        if (accept) begin
          len_d     = len_full;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
            if (len_full == '0)          state_d = DONE;
            else if (len_full > DEPTH_W) state_d = ERROR;
            else                         state_d = DATA;
          end
        end
      end
      DATA: begin
        // Address is latched with the 4th byte so it is stable during mem_we.
        // words_loaded lags by the write cycle, so it equals this word's index.
        if (word_done) begin
          mem_addr_d = words_loaded_q;
          if (words_loaded_q == last_idx) last_d = 1'b1;
        end
        if (asm_word_vld && (words_loaded_q != len_words))
          words_loaded_d = words_loaded_q + AddrSize'(1);
        // last_q already blocked further bytes; leave once the final write lands.
        if (asm_word_vld && last_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      hdr_cnt_q      <= '0;
      words_loaded_q <= '0;
      mem_addr_q     <= '0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      hdr_cnt_q      <= hdr_cnt_d;
      words_loaded_q <= words_loaded_d;
      mem_addr_q     <= mem_addr_d;
      last_q         <= last_d;
    end
  end

  assign mem_we       = asm_word_vld;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = Inst_Size'(asm_word);
  assign words_loaded = words_loaded_q;
  assign busy         = (state_q == LEN) || (state_q == DATA);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign core_hold    = !done;

endmodule : inst_loader

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
// Directed bench for inst_loader with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] words_loaded;
  logic        busy, done, error, core_hold;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  logic [7:0] frame2 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                              8'h13, 8'h05, 8'hA0, 8'h00,
                              8'h73, 8'h00, 8'h10, 8'h00};

  inst_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_loaded (words_loaded),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .core_hold    (core_hold)
  );

  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte, optionally after random idle cycles; returns at posedge+1
  // after the handshake.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  budget;
    bit  ok;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    ok       = 1'b0;
    budget   = 50;
    while (!ok && budget > 0) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk); #1;
      budget--;
    end
    in_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic send_frame2(input bit gaps);
    for (int i = 0; i < 12; i++) send_byte(frame2[i], gaps);
  endtask

  task automatic wait_done();
    int budget = 20;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("done_reached", done, 1);
  endtask

  task automatic check_two_writes(input string pfx);
    check({pfx, "_nwrites"}, wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check({pfx, "_addr0"}, wr_addr_q[0], 0);
      check({pfx, "_data0"}, wr_data_q[0], 32'h00A00513);
      check({pfx, "_addr1"}, wr_addr_q[1], 1);
      check({pfx, "_data1"}, wr_data_q[1], 32'h00100073);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle state
    repeat (5) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready, 0);
    check("rst_core_hold", core_hold, 1);
    check("rst_done",      done, 0);
    check("rst_busy",      busy, 0);
    check("rst_error",     error, 0);
    check("rst_mem_addr",  mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_words",     words_loaded, 0);
    check("idle_no_write", wr_addr_q.size(), 0);

    // Two-word frame, in_valid held high
    pulse_start();
    check("len_busy",     busy, 1);
    check("len_in_ready", in_ready, 1);
    send_frame2(1'b0);
    check("last_in_ready_low", in_ready, 0);
    wait_done();
    check_two_writes("cont");
    check("cont_core_hold", core_hold, 0);
    check("cont_words",     words_loaded, 2);
    check("cont_busy",      busy, 0);

    // Bytes offered in DONE are not accepted
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    check("done_in_ready", in_ready, 0);
    check("done_words",    words_loaded, 2);
    in_valid = 1'b0;

    // Same frame with random gaps
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    check("restart_core_hold", core_hold, 1);
    check("restart_words",     words_loaded, 0);
    send_frame2(1'b1);
    check("gap_last_in_ready_low", in_ready, 0);
    wait_done();
    check_two_writes("gap");
    check("gap_words", words_loaded, 2);

    // Header N = Depth + 1 -> error
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("err_error",     error, 1);
    check("err_in_ready",  in_ready, 0);
    check("err_core_hold", core_hold, 1);
    check("err_busy",      busy, 0);
    check("err_nwrites",   wr_addr_q.size(), 0);

    // Header N = 0 -> done directly
    pulse_start();
    check("zero_error_cleared", error, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
    wait_done();
    check("zero_nwrites",   wr_addr_q.size(), 0);
    check("zero_words",     words_loaded, 0);
    check("zero_core_hold", core_hold, 0);

    // Reset after 6 data bytes
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(frame2[i], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  in_ready, 0);
    check("mid_rst_busy",      busy, 0);
    check("mid_rst_done",      done, 0);
    check("mid_rst_core_hold", core_hold, 1);
    check("mid_rst_words",     words_loaded, 0);
    check("mid_rst_mem_addr",  mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_mem_we",    mem_we, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_frame2(1'b0);
    wait_done();
    check_two_writes("reload");
    check("reload_words", words_loaded, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule : tb_inst_loader

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Write-side counterpart to the instruction memory. It receives a byte stream over a valid/ready handshake, assembles 32-bit little-endian instruction words, and drives a synchronous write port into instruction memory.
- It holds the core in reset until the whole program image has been written.
- It sits between the boot/debug byte source (UART receiver or testbench) and the instruction memory write port.

Parameters:
- AddrSize, 32, width of mem_addr; instruction memory is word-indexed.
- Inst_Size, 32, instruction word width. Fixed at 32; other values are unsupported.
- Depth, 1024, number of instruction words the memory can hold. Upper bound for the loaded program length.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load session.
- in_valid  input  1  byte source has a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  AddrSize  word index being written.
- mem_wdata  output  Inst_Size  assembled instruction word.
- words_loaded  output  AddrSize  count of words written in the current session.
- busy  output  1  a session is in progress.
- done  output  1  sticky; the program was loaded completely.
- error  output  1  sticky; the header length exceeded Depth.
- core_hold  output  1  keeps the core in reset; equals NOT done.

Behaviour:
- Reset (async, any state): state = IDLE. in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, busy=0, done=0, error=0, core_hold=1. Byte counter and shift register are cleared.
- Byte transfer: occurs when in_valid && in_ready at a rising edge. in_ready is combinational from state: 1 only in LEN and DATA.
- Frame format: 4 header bytes giving N (word count, little-endian), then 4*N data bytes. Each group of 4 data bytes forms one word, little-endian: first byte = bits [7:0].
- IDLE: wait for start. On start, go to LEN; clear done, error, words_loaded and the byte counter; set busy=1, core_hold=1.
- LEN: accept 4 bytes into the N register. After the 4th byte:
  - N == 0 → DONE.
  - N > Depth → ERROR.
  - otherwise → DATA.
- DATA: accept bytes into the shift register; a 2-bit byte counter wraps 3→0.
  - On acceptance of the 4th byte of a word, the next cycle shows mem_we=1 for exactly one cycle, with mem_addr = current word index and mem_wdata = the assembled word. words_loaded then increments.
  - Write latency is 1 cycle after the 4th byte handshake.
  - Byte acceptance continues during the mem_we cycle; no bubble is required.
  - After the write of word N-1, go to DONE. in_ready drops in the same cycle the last byte is accepted's successor; no extra byte is accepted.
- DONE: busy=0, done=1, core_hold=0. in_ready=0. Extra input bytes are ignored (not accepted).
- ERROR: busy=0, error=1, core_hold=1, in_ready=0. No memory writes occur in this session.
- start while busy (LEN/DATA) is ignored. start in DONE or ERROR begins a new session, re-asserting core_hold.
- in_valid low mid-word: the partial word is retained indefinitely; there is no timeout.
- mem_addr holds its last written value between strobes. mem_wdata is don't-care when mem_we=0 but must not be X after reset.
- Reset mid-DATA: the session is aborted immediately. Words already written stay in memory; all status outputs return to reset values.
- words_loaded saturates at N; it never wraps, since N ≤ Depth.

Decomposition:
- Package inst_loader_pkg:
  - state enum: IDLE, LEN, DATA, DONE, ERROR.
  - localparam BYTES_PER_WORD = 4.
  - header width constant.
- Optional sub-module byte_to_word_asm: the 4-byte little-endian shift/assemble register with byte counter and word_valid pulse. Reusable by a future data-memory loader.
- The FSM stays in inst_loader.

Test Plan:
- Reset then idle → in_ready=0, core_hold=1, done=0, mem_we never asserted.
- start; header 02 00 00 00; data 13 05 A0 00 73 00 10 00, in_valid held high → two mem_we pulses:
  - addr 0, data 0x00A00513
  - addr 1, data 0x00100073
  - then done=1, core_hold=0, words_loaded=2.
- Same frame with in_valid toggling randomly 50% → identical writes and values; in_ready low after the last byte.
- Header with N = Depth+1 (0x401 at default) → error=1, no mem_we, in_ready=0, core_hold=1.
- Header 00 00 00 00 → DONE directly, zero writes, done=1.
- Assert rst after 6 data bytes of a 2-word load → all outputs at reset values within the same cycle. A later start plus a full frame reloads correctly from addr 0.
